timer_bank: RTL and testbench
=============================

TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of timer channels (legal 1..8).
REQ-002 Parameter CNT_W, default 32, counter/compare width in bits (legal 8..32).
REQ-003 Parameter BASE_ADDR, default 32'h20040, byte base address of the register window.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 addr  input  32  CPU byte address.
REQ-007 wdata  input  32  CPU write data.
REQ-008 we  input  4  CPU byte write enables.
REQ-009 rdata  output  32  read data, combinational from addr.
REQ-010 irq  output  1  interrupt request, registered, level-high.

Function
REQ-011 Register map as offsets from BASE_ADDR: 0x00 CTRL (bit0 global enable), 0x04 PRESCALE (bits15:0), 0x08 IRQ_STATUS (NUM_CH bits, W1C), 0x0C IRQ_ENABLE (NUM_CH bits); channel i at 0x10+0x10*i: +0x0 CNT, +0x4 CMP, +0x8 CFG (bit0 enable, bit1 periodic).
REQ-012 A write occurs only when addr matches a register and we==4'hf; partial-byte writes are ignored.
REQ-013 rdata returns the addressed register zero-extended to 32 bits; unmapped addresses and channels >= NUM_CH read 0.
REQ-014 Prescaler counter counts 0..PRESCALE while CTRL.bit0=1; tick asserts for one cycle when counter==PRESCALE, then the counter returns to 0; tick rate is clk/(PRESCALE+1).
REQ-015 With CTRL.bit0=0 the prescaler counter holds at 0 and no ticks occur.
REQ-016 A write to PRESCALE clears the prescaler counter in the same cycle.
REQ-017 On tick, each channel with CFG.bit0=1 checks CNT==CMP: on a match it sets IRQ_STATUS[i] and loads CNT to 0; otherwise it increments CNT.
REQ-018 On a match with CFG.bit1=0 (one-shot), the channel also clears CFG.bit0.
REQ-019 CNT increment wraps from 2^CNT_W-1 to 0 without setting status.
REQ-020 When a software write to CNT, CMP or CFG coincides with a tick for that channel, the software write takes effect and the tick update is discarded.
REQ-021 When a W1C write to IRQ_STATUS coincides with a hardware set of the same bit, the bit ends up set.
REQ-022 irq is registered from |(IRQ_STATUS & IRQ_ENABLE), so it asserts one cycle after a status bit sets.
REQ-023 Compare-match-to-status latency is one cycle: the status bit is visible on the cycle after the tick.

Reset
REQ-024 While rstn=0 at posedge clk, all registers, the prescaler counter, tick and irq clear to 0.
REQ-025 Reset mid-count abandons all counting; no status bit sets on the cycle after reset deasserts.

Structure
REQ-026 Package timer_bank_pkg holds the register offsets, the CFG bit positions (CFG_EN=0, CFG_PER=1) and the channel stride 0x10.
REQ-027 Sub-module timer_channel holds CNT, CMP and CFG for one channel; it takes tick and the write strobes and outputs the match pulse; timer_bank instantiates NUM_CH copies via generate.
REQ-028 timer_bank owns address decode, the prescaler, IRQ_STATUS, IRQ_ENABLE, the read mux and irq.

Verification
REQ-029 PRESCALE=0, CMP0=3, CFG0=3, CTRL=1 -> IRQ_STATUS[0] sets every 4 cycles; CNT0 sequence is 0,1,2,3,0.
REQ-030 PRESCALE=9, CMP1=1, CFG1=1 (one-shot) -> status[1] sets 20 cycles after enable; CFG1 then reads 0 and CNT1 holds at 0.
REQ-031 CNT_W=8, CMP=0, CNT=8'hFE, periodic -> CNT goes FF then 00 with no status set, then a match on the next tick.
REQ-032 IRQ_ENABLE=1, status[0] set -> irq=1; write IRQ_STATUS=1 on the cycle of a new match -> status stays 1; a later W1C with no match -> irq falls one cycle after status clears.
REQ-033 A partial write (we=4'h3) to CMP0 -> CMP0 unchanged; a read of BASE+0x7C with NUM_CH=4 -> 0.
REQ-034 rstn=0 pulse while CNT2=5 -> all registers and irq read 0 afterwards; CTRL=0 with CFG enables set -> no ticks occur.

Source files
------------

// File: rtl/timer_bank_pkg.sv
`default_nettype none
// ============================================================================
// timer_bank_pkg : register map, CFG bit positions and channel register enums
// Revision       : 1.0
// ============================================================================
package timer_bank_pkg;

  localparam logic [31:0] OFF_CTRL       = 32'h00;
  localparam logic [31:0] OFF_PRESCALE   = 32'h04;
  localparam logic [31:0] OFF_IRQ_STATUS = 32'h08;
  localparam logic [31:0] OFF_IRQ_ENABLE = 32'h0C;
  localparam logic [31:0] CH_BASE        = 32'h10;
  localparam logic [31:0] CH_STRIDE      = 32'h10;

  localparam int CFG_EN  = 0;
  localparam int CFG_PER = 1;

  localparam int PRESCALE_W = 16;

  typedef enum logic [3:0] {
    CH_REG_CNT = 4'h0,
    CH_REG_CMP = 4'h4,
    CH_REG_CFG = 4'h8
  } ch_reg_e;

endpackage
`default_nettype wire

// File: rtl/timer_bank_if.sv
`default_nettype none
// ============================================================================
// timer_bank_if : CPU register bus (address, write data, byte enables, read, irq)
// Revision      : 1.0
// ============================================================================
interface timer_bank_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr,
    output wdata,
    output we,
    input  rdata,
    input  irq
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we,
    output rdata,
    output irq
  );

endinterface
`default_nettype wire

// File: rtl/timer_bank_channel.sv
`default_nettype none
// ============================================================================
// timer_channel : one compare channel holding CNT, CMP and CFG; pulses on match
// Revision      : 1.0
// ============================================================================
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] wdata_i,
  input  logic [1:0]       cfg_wdata_i,
  input  logic             cnt_we_i,
  input  logic             cmp_we_i,
  input  logic             cfg_we_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cmp_o,
  output logic [1:0]       cfg_o,
  output logic             match_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic [1:0]       cfg_q, cfg_d;
  logic             w_sw_wr;
  logic             w_active;

  // Any software access to this channel wins over the tick update.
  assign w_sw_wr  = cnt_we_i | cmp_we_i | cfg_we_i;
  assign w_active = tick_i & cfg_q[CFG_EN] & ~w_sw_wr;
  assign match_o  = w_active & (cnt_q == cmp_q);

  always_comb begin
    cnt_d = cnt_q;
    cmp_d = cmp_q;
    cfg_d = cfg_q;
    if (cnt_we_i) cnt_d = wdata_i;
    if (cmp_we_i) cmp_d = wdata_i;
    if (cfg_we_i) cfg_d = cfg_wdata_i;
    if (w_active) begin
      if (cnt_q == cmp_q) begin
        cnt_d = '0;
        if (!cfg_q[CFG_PER]) cfg_d[CFG_EN] = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      cmp_q <= '0;
      cfg_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cmp_q <= cmp_d;
      cfg_q <= cfg_d;
    end
  end

  assign cnt_o = cnt_q;
  assign cmp_o = cmp_q;
  assign cfg_o = cfg_q;

endmodule
`default_nettype wire

// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
// timer_bank : prescaled multi-channel compare timer with W1C interrupt status
// Revision   : 1.0
// ============================================================================
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h20040
) (
  input  logic        clk,
  input  logic        rstn,
  timer_bank_if.slave bus
);

  logic [31:0]           w_off;
  logic [31:0]           w_ch_rel;
  logic [3:0]            w_sub;
  logic                  w_in_win;
  logic                  w_wr;
  logic                  w_sel_ctrl;
  logic                  w_sel_prescale;
  logic                  w_sel_status;
  logic                  w_sel_ien;
  logic                  w_tick;
  logic [NUM_CH-1:0]     w_ch_hit;
  logic [NUM_CH-1:0]     w_match;
  logic [CNT_W-1:0]      w_cnt [NUM_CH];
  logic [CNT_W-1:0]      w_cmp [NUM_CH];
  logic [1:0]            w_cfg [NUM_CH];
  logic [31:0]           w_rdata;

  logic                  ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [NUM_CH-1:0]     status_q, status_d;
  logic [NUM_CH-1:0]     ien_q, ien_d;
  logic                  irq_q, irq_d;

  // Only word-aligned addresses at or above the base can hit a register.
  assign w_off    = bus.addr - BASE_ADDR;
  assign w_in_win = (bus.addr >= BASE_ADDR) && (bus.addr[1:0] == 2'b00);
  assign w_wr     = (bus.we == 4'hf);
  assign w_ch_rel = w_off - CH_BASE;
  assign w_sub    = w_ch_rel[3:0];

  assign w_sel_ctrl     = w_in_win && (w_off == OFF_CTRL);
  assign w_sel_prescale = w_in_win && (w_off == OFF_PRESCALE);
  assign w_sel_status   = w_in_win && (w_off == OFF_IRQ_STATUS);
  assign w_sel_ien      = w_in_win && (w_off == OFF_IRQ_ENABLE);

  assign w_tick = ctrl_q && (pcnt_q == prescale_q);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [31:0] c_ch_lo = CH_STRIDE * 32'(i);

    assign w_ch_hit[i] = w_in_win && (w_off >= CH_BASE) &&
                         (w_ch_rel >= c_ch_lo) && (w_ch_rel < c_ch_lo + CH_STRIDE);

    timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rstn        (rstn),
      .tick_i      (w_tick),
      .wdata_i     (bus.wdata[CNT_W-1:0]),
      .cfg_wdata_i (bus.wdata[1:0]),
      .cnt_we_i    (w_wr && w_ch_hit[i] && (w_sub == CH_REG_CNT)),
      .cmp_we_i    (w_wr && w_ch_hit[i] && (w_sub == CH_REG_CMP)),
      .cfg_we_i    (w_wr && w_ch_hit[i] && (w_sub == CH_REG_CFG)),
      .cnt_o       (w_cnt[i]),
      .cmp_o       (w_cmp[i]),
      .cfg_o       (w_cfg[i]),
      .match_o     (w_match[i])
    );
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    ien_d      = ien_q;
    status_d   = status_q;
    irq_d      = |(status_q & ien_q);

    if (w_wr && w_sel_ctrl)     ctrl_d     = bus.wdata[0];
    if (w_wr && w_sel_prescale) prescale_d = bus.wdata[PRESCALE_W-1:0];
    if (w_wr && w_sel_ien)      ien_d      = bus.wdata[NUM_CH-1:0];

    if (w_wr && w_sel_prescale)  pcnt_d = '0;
    else if (!ctrl_q || w_tick)  pcnt_d = '0;
    else                         pcnt_d = pcnt_q + PRESCALE_W'(1);

    // Hardware set is OR-ed in after the clear so it wins on collision.
    if (w_wr && w_sel_status) status_d = status_q & ~bus.wdata[NUM_CH-1:0];
    status_d = status_d | w_match;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ctrl_q     <= 1'b0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      status_q   <= '0;
      ien_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      status_q   <= status_d;
      ien_q      <= ien_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel_ctrl)     w_rdata[0]              = ctrl_q;
    if (w_sel_prescale) w_rdata[PRESCALE_W-1:0] = prescale_q;
    if (w_sel_status)   w_rdata[NUM_CH-1:0]     = status_q;
    if (w_sel_ien)      w_rdata[NUM_CH-1:0]     = ien_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch_hit[i]) begin
        case (w_sub)
          CH_REG_CNT: w_rdata[CNT_W-1:0] = w_cnt[i];
          CH_REG_CMP: w_rdata[CNT_W-1:0] = w_cmp[i];
          CH_REG_CFG: w_rdata[1:0]       = w_cfg[i];
          default:    ;
        endcase
      end
    end
  end

  assign bus.rdata = w_rdata;
  assign bus.irq   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_bank.sv
`default_nettype none
// ============================================================================
// tb_timer_bank : directed scenarios plus randomized traffic against a model
// Revision      : 1.0
// ============================================================================
module tb_timer_bank;

  localparam logic [31:0] BASE = 32'h20040;
  localparam int          NCH  = 4;
  localparam logic [3:0]  WF   = 4'hf;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  timer_bank_if ifa ();
  timer_bank_if ifb ();

  timer_bank #(.NUM_CH(NCH), .CNT_W(32), .BASE_ADDR(BASE)) dut (
    .clk (clk), .rstn (rstn), .bus (ifa)
  );
  timer_bank #(.NUM_CH(2), .CNT_W(8), .BASE_ADDR(BASE)) dut8 (
    .clk (clk), .rstn (rstn), .bus (ifb)
  );

  always #5 clk = ~clk;

  // Reference model of the 4-channel, 32-bit instance.
  logic        m_ctrl;
  logic [15:0] m_pre, m_pc;
  logic [3:0]  m_st, m_ie;
  logic        m_irq;
  logic [31:0] m_cnt [NCH];
  logic [31:0] m_cmp [NCH];
  logic [1:0]  m_cfg [NCH];

  function automatic logic [31:0] ch_addr(input int ch, input int sub);
    return BASE + 32'h10 + 32'h10 * 32'(ch) + 32'(sub);
  endfunction

  // -1 unmapped, 0..3 global registers, 4+3*ch+sub channel registers
  function automatic int reg_id(input logic [31:0] ad);
    logic [31:0] off;
    if (ad < BASE || ad[1:0] != 2'b00) return -1;
    off = ad - BASE;
    if (off < 32'h10) return int'(off >> 2);
    if (off >= 32'h10 + 32'h10 * NCH) return -1;
    if (off[3:2] == 2'b11) return -1;
    return 4 + 3 * int'((off - 32'h10) >> 4) + int'(off[3:2]);
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] ad);
    int id;
    int ch;
    id = reg_id(ad);
    if (id == 0) return {31'b0, m_ctrl};
    if (id == 1) return {16'b0, m_pre};
    if (id == 2) return {28'b0, m_st};
    if (id == 3) return {28'b0, m_ie};
    if (id < 0) return 32'h0;
    ch = (id - 4) / 3;
    case ((id - 4) % 3)
      0:       return m_cnt[ch];
      1:       return m_cmp[ch];
      default: return {30'b0, m_cfg[ch]};
    endcase
  endfunction

  task automatic mdl_reset();
    m_ctrl = 0; m_pre = 0; m_pc = 0; m_st = 0; m_ie = 0; m_irq = 0;
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_cmp[i] = 0; m_cfg[i] = 0;
    end
  endtask

  task automatic mdl_step(input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] w);
    int         id;
    bit         tick;
    logic [3:0] hit;
    logic       irq_n;
    id    = (w == 4'hf) ? reg_id(ad) : -1;
    tick  = m_ctrl && (m_pc == m_pre);
    hit   = 4'h0;
    irq_n = |(m_st & m_ie);
    for (int ch = 0; ch < NCH; ch++) begin
      if (id >= 4 + 3 * ch && id < 7 + 3 * ch) begin
        case (id - 4 - 3 * ch)
          0:       m_cnt[ch] = wd;
          1:       m_cmp[ch] = wd;
          default: m_cfg[ch] = wd[1:0];
        endcase
      end else if (tick && m_cfg[ch][0]) begin
        if (m_cnt[ch] == m_cmp[ch]) begin
          hit[ch]   = 1'b1;
          m_cnt[ch] = 0;
          if (!m_cfg[ch][1]) m_cfg[ch][0] = 1'b0;
        end else begin
          m_cnt[ch] = m_cnt[ch] + 1;
        end
      end
    end
    m_st = ((id == 2) ? (m_st & ~wd[3:0]) : m_st) | hit;
    if (id == 1 || !m_ctrl || tick) m_pc = 0;
    else                            m_pc = m_pc + 1;
    if (id == 0) m_ctrl = wd[0];
    if (id == 1) m_pre  = wd[15:0];
    if (id == 3) m_ie   = wd[3:0];
    m_irq = irq_n;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int s, input logic [31:0] ad, output logic [31:0] d);
    if (s == 0) begin ifa.addr = ad; ifa.we = 4'h0; end
    else        begin ifb.addr = ad; ifb.we = 4'h0; end
    #1;
    d = (s == 0) ? ifa.rdata : ifb.rdata;
  endtask

  task automatic cyc(input int s, input logic [31:0] ad, input logic [31:0] dat, input logic [3:0] w);
    if (s == 0) begin ifa.addr = ad; ifa.wdata = dat; ifa.we = w; end
    else        begin ifb.addr = ad; ifb.wdata = dat; ifb.we = w; end
    mdl_step(ifa.addr, ifa.wdata, ifa.we);
    @(posedge clk); #1;
    ifa.we = 4'h0;
    ifb.we = 4'h0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      ifa.we = 4'h0;
      mdl_step(ifa.addr, ifa.wdata, 4'h0);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; ifa.we = 4'h0; ifb.we = 4'h0;
    @(posedge clk); #1;
    rstn = 1'b1;
    mdl_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] v;
  logic [31:0] alist [21];
  logic [7:0]  exp31 [4];
  int          found;

  initial begin
    ifa.addr = BASE; ifa.wdata = 0; ifa.we = 0;
    ifb.addr = BASE; ifb.wdata = 0; ifb.we = 0;
    mdl_reset();
    do_reset();

    rd(0, BASE, v);        chk("rst_ctrl", v, 0);
    rd(0, BASE + 4, v);    chk("rst_prescale", v, 0);
    rd(0, BASE + 8, v);    chk("rst_status", v, 0);
    rd(0, ch_addr(0, 0), v); chk("rst_cnt0", v, 0);
    chk("rst_irq", ifa.irq, 0);

    // Free-running periodic compare with prescale 0.
    cyc(0, BASE + 4, 0, WF);
    cyc(0, ch_addr(0, 4), 3, WF);
    cyc(0, ch_addr(0, 8), 3, WF);
    cyc(0, BASE, 1, WF);
    for (int k = 0; k < 5; k++) begin
      rd(0, ch_addr(0, 0), v); chk($sformatf("p29_cnt0_%0d", k), v, 32'(k % 4));
      rd(0, BASE + 8, v);      chk($sformatf("p29_stat_%0d", k), v, (k == 4) ? 1 : 0);
      idle(1);
    end
    cyc(0, BASE + 8, 1, WF);
    rd(0, BASE + 8, v); chk("p29_w1c", v, 0);
    idle(1);
    rd(0, BASE + 8, v); chk("p29_gap", v, 0);
    idle(1);
    rd(0, BASE + 8, v); chk("p29_period4", v, 1);

    // Interrupt enable, W1C collision and irq fall.
    cyc(0, BASE + 12, 1, WF);
    chk("p32_irq_lag", ifa.irq, 0);
    idle(1);
    chk("p32_irq_on", ifa.irq, 1);
    found = 0;
    for (int k = 0; k < 8 && found == 0; k++) begin
      rd(0, ch_addr(0, 0), v);
      if (v == 3) found = 1;
      else idle(1);
    end
    chk("p32_wait_cnt3", found, 1);
    cyc(0, BASE + 8, 1, WF);
    rd(0, BASE + 8, v);      chk("p32_collide_stat", v, 1);
    rd(0, ch_addr(0, 0), v); chk("p32_collide_cnt", v, 0);
    cyc(0, BASE + 8, 1, WF);
    rd(0, BASE + 8, v); chk("p32_clear_stat", v, 0);
    chk("p32_irq_still", ifa.irq, 1);
    idle(1);
    chk("p32_irq_fall", ifa.irq, 0);
    cyc(0, ch_addr(0, 8), 0, WF);
    cyc(0, BASE + 12, 0, WF);
    cyc(0, BASE + 8, 32'hF, WF);

    // One-shot channel 1 with prescale 9.
    cyc(0, BASE, 0, WF);
    cyc(0, BASE + 4, 9, WF);
    cyc(0, ch_addr(1, 4), 1, WF);
    cyc(0, ch_addr(1, 8), 1, WF);
    cyc(0, BASE, 1, WF);
    idle(19);
    rd(0, BASE + 8, v); chk("p30_stat_19", v, 0);
    idle(1);
    rd(0, BASE + 8, v);      chk("p30_stat_20", v, 2);
    rd(0, ch_addr(1, 8), v); chk("p30_cfg1", v, 0);
    idle(15);
    rd(0, ch_addr(1, 0), v); chk("p30_cnt1_hold", v, 0);
    cyc(0, BASE + 8, 32'hF, WF);

    // Partial writes and unmapped reads.
    cyc(0, ch_addr(0, 4), 32'h55, 4'h3);
    rd(0, ch_addr(0, 4), v); chk("p33_cmp0_we3", v, 3);
    cyc(0, ch_addr(0, 4), 32'h66, 4'hc);
    rd(0, ch_addr(0, 4), v); chk("p33_cmp0_wec", v, 3);
    rd(0, BASE + 32'h7C, v); chk("p33_unmapped_7c", v, 0);
    rd(0, BASE + 32'h50, v); chk("p33_ch4", v, 0);

    // Reset pulse mid-state.
    cyc(0, ch_addr(2, 0), 5, WF);
    rd(0, ch_addr(2, 0), v); chk("p34_cnt2_pre", v, 5);
    cyc(0, BASE + 12, 32'hF, WF);
    do_reset();
    rd(0, ch_addr(2, 0), v); chk("p34_cnt2", v, 0);
    rd(0, BASE, v);          chk("p34_ctrl", v, 0);
    rd(0, BASE + 4, v);      chk("p34_prescale", v, 0);
    rd(0, ch_addr(0, 4), v); chk("p34_cmp0", v, 0);
    rd(0, BASE + 12, v);     chk("p34_ien", v, 0);
    rd(0, BASE + 8, v);      chk("p34_status", v, 0);
    chk("p34_irq", ifa.irq, 0);
    cyc(0, ch_addr(2, 8), 3, WF);
    cyc(0, ch_addr(0, 8), 3, WF);
    idle(10);
    rd(0, BASE + 8, v);      chk("p34_noticks_stat", v, 0);
    rd(0, ch_addr(2, 0), v); chk("p34_noticks_cnt2", v, 0);

    // 8-bit counter wrap on the narrow instance.
    exp31[0] = 8'hFE; exp31[1] = 8'hFF; exp31[2] = 8'h00; exp31[3] = 8'h00;
    cyc(1, BASE + 4, 0, WF);
    cyc(1, ch_addr(0, 4), 0, WF);
    cyc(1, ch_addr(0, 0), 32'hFE, WF);
    cyc(1, ch_addr(0, 8), 3, WF);
    cyc(1, BASE, 1, WF);
    for (int k = 0; k < 4; k++) begin
      rd(1, ch_addr(0, 0), v); chk($sformatf("p31_cnt_%0d", k), v, {24'b0, exp31[k]});
      rd(1, BASE + 8, v);      chk($sformatf("p31_stat_%0d", k), v, (k == 3) ? 1 : 0);
      idle(1);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 16; i++)
      alist[i] = (i < 4) ? BASE + 32'(4 * i) : ch_addr((i - 4) / 3, 4 * ((i - 4) % 3));
    alist[16] = BASE + 32'h1C;
    alist[17] = BASE + 32'h50;
    alist[18] = BASE + 32'h7C;
    alist[19] = BASE + 32'h2;
    alist[20] = BASE - 32'h4;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra, wa, wd;
      logic [3:0]  ww;
      int          id;
      int          pick;
      ra = alist[$urandom_range(0, 20)];
      rd(0, ra, v);
      chk($sformatf("rnd_rd_%0d_%h", n, ra), v, mdl_read(ra));
      chk($sformatf("rnd_irq_%0d", n), ifa.irq, m_irq);
      if ($urandom_range(0, 9) < 4) begin
        idle(1);
      end else begin
        wa   = alist[$urandom_range(0, 20)];
        id   = reg_id(wa);
        pick = $urandom_range(0, 5);
        ww   = (pick < 4) ? 4'hf : (pick == 4) ? 4'h3 : 4'hc;
        if (id == 0)      wd = {$urandom_range(0, 1), 1'b0} | (($urandom_range(0, 9) < 8) ? 1 : 0);
        else if (id == 1) wd = ($urandom & 32'hFFFF0000) | $urandom_range(0, 3);
        else if (id >= 4 && ((id - 4) % 3) != 2) wd = $urandom_range(0, 6);
        else              wd = $urandom;
        cyc(0, wa, wd, ww);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
